// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared types, constants and parameter check for the on-chip memory
package onchip_mem_pkg;

   typedef enum logic [1:0] {
      IDLE_RST = 2'd0,
      CLEAR    = 2'd1,
      READY    = 2'd2
   } mem_state_e;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 2;

   function automatic bit params_ok(input int data_w, input int read_latency);
      return (data_w % 8 == 0) &&
             (read_latency >= READ_LATENCY_MIN) &&
             (read_latency <= READ_LATENCY_MAX);
   endfunction

endpackage

// File: rtl/onchip_mem_bram.sv
// rtl/onchip_mem_bram.sv - inferred byte-enabled single-port RAM with registered read address
module onchip_mem_bram
   import onchip_mem_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 1024,
   parameter  int ADDR_W = $clog2(DEPTH),
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] raddr_q;

   // No reset here so the array and address register map onto block RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < BE_W; b++) begin
               if (be[b]) begin
                  mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end
         raddr_q <= addr;
      end
   end

   assign rdata = mem_q[raddr_q];

endmodule

// File: rtl/onchip_memory_pipelined.sv
// rtl/onchip_memory_pipelined.sv - Avalon-MM on-chip RAM slave with clear sweep and pipelined reads
module onchip_memory_pipelined
   import onchip_mem_pkg::*;
#(
   parameter  int DATA_W         = 32,
   parameter  int DEPTH          = 1024,
   parameter  int READ_LATENCY   = 1,
   parameter  bit CLEAR_ON_RESET = 1'b1,
   localparam int ADDR_W         = $clog2(DEPTH),
   localparam int BE_W           = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [BE_W-1:0]   byteenable,
   input  logic [DATA_W-1:0] writedata,
   input  logic              clken,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid,
   output logic              waitrequest,
   output logic              init_done
);

   if (!params_ok(DATA_W, READ_LATENCY)) begin : g_param_check
      $error("onchip_memory_pipelined: DATA_W must be a multiple of 8 and READ_LATENCY 1 or 2");
   end

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_q, clr_d;
   logic              clearing;
   logic              in_range;
   logic              accept, wr_acc, rd_acc;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [BE_W-1:0]   ram_be;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   logic              v1_q, v1_d;
   logic              oor1_q, oor1_d;
   logic [DATA_W-1:0] s1_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE_RST;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      if (clken) begin
         case (state_q)
            IDLE_RST: state_d = CLEAR_ON_RESET ? CLEAR : READY;
            CLEAR: begin
               if (clr_q == LAST_ADDR) begin
                  state_d = READY;
                  clr_d   = '0;
               end else begin
                  clr_d = clr_q + 1'b1;
               end
            end
            READY:    state_d = READY;
            default:  state_d = IDLE_RST;
         endcase
      end
   end

   always_comb begin
      init_done   = (state_q == READY);
      clearing    = (state_q == CLEAR);
      waitrequest = (state_q != READY) | !clken;
   end

   // Power-of-two depths cover the whole address space, so no compare is needed.
   if (DEPTH == (1 << ADDR_W)) begin : g_range_full
      assign in_range = 1'b1;
   end else begin : g_range_cmp
      assign in_range = (address < ADDR_W'(DEPTH));
   end

   // A simultaneous read and write is treated as a write; the read is dropped.
   assign accept = chipselect & (read | write) & !waitrequest;
   assign wr_acc = accept & write;
   assign rd_acc = accept & read & !write;

   always_comb begin
      ram_we    = clearing ? clken : (wr_acc & in_range);
      ram_addr  = clearing ? clr_q : address;
      ram_be    = clearing ? {BE_W{1'b1}} : byteenable;
      ram_wdata = clearing ? '0 : writedata;
   end

   onchip_mem_bram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_bram (
      .clk   (clk),
      .en    (clken),
      .we    (ram_we),
      .be    (ram_be),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      v1_d   = clken ? rd_acc : v1_q;
      oor1_d = clken ? (rd_acc & !in_range) : oor1_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q   <= 1'b0;
         oor1_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         oor1_q <= oor1_d;
      end
   end

   // Out-of-range reads and idle cycles present zero on the data bus.
   assign s1_data = (v1_q & !oor1_q) ? ram_rdata : '0;

   if (READ_LATENCY == 2) begin : g_lat2
      logic              v2_q, v2_d;
      logic [DATA_W-1:0] d2_q, d2_d;

      always_comb begin
         v2_d = clken ? v1_q : v2_q;
         d2_d = clken ? s1_data : d2_q;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v2_d;
            d2_q <= d2_d;
         end
      end

      assign readdata      = d2_q;
      assign readdatavalid = v2_q & clken;
   end else begin : g_lat1
      assign readdata      = s1_data;
      assign readdatavalid = v1_q & clken;
   end

endmodule
